// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_reader
//  Purpose  : Read-side engine for a show-ahead synchronous FIFO. Waits until
//             the FIFO holds the programmed burst length (or a fill timeout
//             expires), then drains that burst onto a registered valid/ready
//             stream framed with a last flag. One word per cycle when the
//             sink is ready.
//  Ports    : clk, rst            - clock, async active-high reset
//             enable_i            - level-sensitive start/continue bursting
//             burst_len_i         - requested burst length (sampled on FILL entry)
//             fifo_rd_en_o        - FIFO pop strobe (combinational)
//             fifo_rd_data_i      - FIFO head word (show-ahead)
//             fifo_empty_i        - FIFO empty flag
//             fifo_count_i        - FIFO occupancy
//             m_valid_o/m_data_o/m_last_o/m_short_o, m_ready_i - output stream
//             busy_o              - engine not idle
//             burst_count_o       - completed bursts (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_WIDTH     = $clog2(FIFO_DEPTH),
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int TMR_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH:0]   burst_len_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_count_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  m_short_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic [15:0]           burst_count_o
);

  localparam int                  CW         = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]        C_MAX_LEN  = CW'(MAX_BURST);
  localparam logic [CW-1:0]        C_ONE      = CW'(1);
  localparam logic [TMR_WIDTH-1:0] C_TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           len_q;
  logic [CW-1:0]           rem_q;
  logic [TMR_WIDTH-1:0]    timer_q;
  logic                    short_q;
  logic                    m_valid_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_last_q;
  logic                    m_short_q;
  logic [15:0]             burst_count_q;

  logic [CW-1:0]           len_d;
  logic                    pop_d;
  logic                    accept_d;

  // Clamp the requested length into 1..MAX_BURST.
  always_comb begin
    len_d = burst_len_i;
    if (burst_len_i == '0) begin
      len_d = C_ONE;
    end else if (burst_len_i > C_MAX_LEN) begin
      len_d = C_MAX_LEN;
    end
  end

  // Pop only when the output register is free or being emptied this cycle,
  // so a held word is never overwritten.
  assign pop_d    = (state_q == S_BURST) && !fifo_empty_i && (rem_q != '0) &&
                    (!m_valid_q || m_ready_i);
  assign accept_d = m_valid_q && m_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= C_ONE;
      rem_q         <= '0;
      timer_q       <= '0;
      short_q       <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_short_q     <= 1'b0;
      burst_count_q <= '0;
    end else begin
      burst_count_q <= burst_count_q + {15'd0, accept_d && m_last_q};

      // Output register: a pop loads a new word, otherwise an accept frees it.
      if (pop_d) begin
        m_data_q  <= fifo_rd_data_i;
        m_valid_q <= 1'b1;
        m_last_q  <= (rem_q == C_ONE);
        m_short_q <= short_q;
      end else if (accept_d) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q <= S_FILL;
            len_q   <= len_d;
            timer_q <= '0;
          end
        end
        S_FILL: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (fifo_count_i >= len_q) begin
            state_q <= S_BURST;
            rem_q   <= len_q;
            short_q <= 1'b0;
          end else if (fifo_count_i != '0) begin
            // Leaving FILL at the terminal count keeps the timer from wrapping.
            if (timer_q == C_TMR_LAST) begin
              state_q <= S_BURST;
              rem_q   <= fifo_count_i;
              short_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TMR_WIDTH'(1);
            end
          end else begin
            timer_q <= '0;
          end
        end
        S_BURST: begin
          if (pop_d) begin
            rem_q <= rem_q - C_ONE;
            if (rem_q == C_ONE) begin
              if (enable_i) begin
                state_q <= S_FILL;
                len_q   <= len_d;
                timer_q <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en_o  = pop_d;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_last_o      = m_last_q;
  assign m_short_o     = m_short_q;
  assign busy_o        = (state_q != S_IDLE);
  assign burst_count_o = burst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_burst_reader
//  Purpose  : Self-checking bench for fifo_burst_reader. A queue-based FIFO
//             feeds the design; expected beats are derived from the queue
//             contents by chunking them into clamped-length bursts with a
//             short (timeout) remainder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int CW   = AW + 1;
  localparam int MAXB = 8;
  localparam int TMO  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic [CW-1:0] burst_len_i = '0;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_rd_data_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic [CW-1:0] fifo_count_i = '0;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_short_o;
  logic          m_ready_i = 1'b0;
  logic          busy_o;
  logic [15:0]   burst_count_o;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .burst_len_i(burst_len_i),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i(fifo_empty_i), .fifo_count_i(fifo_count_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_short_o(m_short_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .burst_count_o(burst_count_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          sht;
  } beat_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [15:0]   model_bc = '0;
  int            cyc, acc_cnt, first_acc, last_acc;

  // Pre-edge view of the handshake, captured at each rising edge.
  bit            s_acc, s_pop, s_stall, s_last, s_short;
  logic [DW-1:0] s_data;
  always @(posedge clk) begin
    s_acc   <= m_valid_o && m_ready_i;
    s_pop   <= fifo_rd_en_o;
    s_stall <= m_valid_o && !m_ready_i;
    s_data  <= m_data_o;
    s_last  <= m_last_o;
    s_short <= m_short_o;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty_i   = (fifo_q.size() == 0);
    fifo_count_i   = CW'(fifo_q.size());
    fifo_rd_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic step();
    beat_t         b;
    logic [DW-1:0] tmp;
    @(negedge clk);
    cyc++;
    if (s_pop) begin
      if (fifo_q.size() == 0) check_val("underflow", 1, 0);
      else tmp = fifo_q.pop_front();
    end
    if (s_stall) begin
      check_val("no_pop_on_stall", {31'd0, s_pop}, 0);
      check_val("hold_word", {m_valid_o, m_data_o, m_last_o, m_short_o},
                {1'b1, s_data, s_last, s_short});
    end
    if (s_acc) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 1, 0);
      end else begin
        b = exp_q.pop_front();
        check_val("beat", {s_data, s_last, s_short}, {b.d, b.last, b.sht});
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      acc_cnt++;
      if (s_last) begin
        model_bc = model_bc + 16'd1;
        check_val("burst_count", {16'd0, burst_count_o}, {16'd0, model_bc});
      end
    end
    fifo_refresh();
  endtask

  // Push new words, then chunk the whole FIFO content into expected bursts.
  task automatic plan(input int n, input int base, input int blen,
                      output int exp_lat, output int len);
    int sz, idx, rem;
    beat_t b;
    for (int i = 0; i < n; i++)
      fifo_q.push_back((base < 0) ? DW'($urandom) : DW'(base + i));
    fifo_refresh();
    len = (blen == 0) ? 1 : ((blen > MAXB) ? MAXB : blen);
    sz  = fifo_q.size();
    idx = 0;
    while (sz - idx >= len) begin
      for (int k = 0; k < len; k++) begin
        b.d = fifo_q[idx + k]; b.last = (k == len - 1); b.sht = 1'b0;
        exp_q.push_back(b);
      end
      idx += len;
    end
    rem = sz - idx;
    for (int k = 0; k < rem; k++) begin
      b.d = fifo_q[idx + k]; b.last = (k == rem - 1); b.sht = 1'b1;
      exp_q.push_back(b);
    end
    // enable sampled at edge 1, FILL decision at edge 2 (or after the timer
    // runs out), pop one edge later.
    exp_lat = (sz >= len) ? 3 : TMO + 2;
  endtask

  task automatic run_scenario(input int n, input int base, input int blen,
                              input int mode, input int drop_after, input int rst_after);
    int exp_lat, len, lat, nbeats;
    enable_i  = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 60 && (busy_o || m_valid_o); i++) step();
    check_val("idle_before", {30'd0, busy_o, m_valid_o}, 0);

    plan(n, base, blen, exp_lat, len);
    nbeats      = exp_q.size();
    burst_len_i = CW'(blen);
    enable_i    = 1'b1;
    m_ready_i   = (mode == 1) ? 1'b0 : 1'b1;
    cyc = 0; acc_cnt = 0; first_acc = -1; last_acc = -1; lat = -1;

    while (exp_q.size() > 0 && cyc < 3000) begin
      step();
      if (lat < 0 && m_valid_o) lat = cyc;
      if (drop_after > 0 && acc_cnt >= drop_after) enable_i = 1'b0;
      if (rst_after > 0 && acc_cnt >= rst_after) begin
        #1 rst = 1'b1;
        #1;
        check_val("rst_outputs", {28'd0, m_valid_o, busy_o, fifo_rd_en_o, m_last_o}, 0);
        check_val("rst_data", {24'd0, m_data_o}, 0);
        for (int k = 0; k < 2; k++) begin
          step();
          check_val("no_pop_in_rst", {31'd0, fifo_rd_en_o}, 0);
        end
        exp_q.delete();
        model_bc = '0;
        check_val("rst_burst_count", {16'd0, burst_count_o}, 0);
        check_val("words_left", fifo_q.size(), n - rst_after - 1);
        rst      = 1'b0;
        enable_i = 1'b0;
        return;
      end
      case (mode)
        0:       m_ready_i = 1'($urandom_range(0, 1));
        1:       m_ready_i = ~m_ready_i;
        default: m_ready_i = 1'b1;
      endcase
    end
    check_val("all_beats_seen", exp_q.size(), 0);
    if (nbeats > 0) check_val("first_latency", lat, exp_lat);
    if (mode == 2 && nbeats > 0 && nbeats <= len)
      check_val("no_bubble", last_acc - first_acc, nbeats - 1);
    check_val("fifo_drained", fifo_q.size(), 0);
    if (drop_after > 0) begin
      step();
      check_val("busy_after_drop", {31'd0, busy_o}, 0);
    end
  endtask

  initial begin
    fifo_refresh();
    repeat (2) @(negedge clk);
    check_val("reset_flags", {27'd0, m_valid_o, m_last_o, m_short_o, busy_o, fifo_rd_en_o}, 0);
    check_val("reset_data_cnt", {8'd0, m_data_o, burst_count_o}, 0);
    rst = 1'b0;

    run_scenario(4, 8'h11, 4, 2, 0, 0);    // basic burst
    run_scenario(2, 8'hA0, 4, 0, 0, 0);    // timeout short burst
    run_scenario(8, -1, 8, 1, 0, 0);       // toggling ready
    run_scenario(3, -1, 0, 0, 0, 0);       // length 0 -> bursts of 1
    run_scenario(12, -1, 20, 0, 0, 0);     // clamp to 8, short remainder
    for (int r = 0; r < 6; r++)
      run_scenario($urandom_range(1, 16), -1, $urandom_range(0, 20),
                   $urandom_range(0, 2), 0, 0);
    run_scenario(8, -1, 8, 2, 0, 3);       // reset mid-burst
    run_scenario(0, -1, 4, 2, 0, 0);       // fresh burst from remaining head
    run_scenario(4, -1, 4, 2, 1, 0);       // enable dropped mid-burst

    force dut.burst_count_q = 16'hFFFF;
    step();
    release dut.burst_count_q;
    model_bc = 16'hFFFF;
    check_val("bc_preload", {16'd0, burst_count_o}, 32'h0000FFFF);
    run_scenario(1, -1, 1, 2, 0, 0);       // wraps to 0
    check_val("bc_wrapped", {16'd0, burst_count_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side engine for the synchronous FIFO.
- Waits until the FIFO holds a programmed burst length, or a fill timeout expires, then drains that burst onto a registered valid/ready output stream, framed with a last flag.
- Sits between the FIFO read port and downstream packet consumers.
- Sustains one word per cycle when the sink is ready.

Parameters:
- DATA_WIDTH, 8, FIFO word width.
- FIFO_DEPTH, 16, depth of the attached FIFO.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), FIFO address width; count and length ports are ADDR_WIDTH+1 bits.
- MAX_BURST, 8, largest burst length; must be ≤ FIFO_DEPTH.
- TIMEOUT_CYCLES, 32, fill-wait cycles before a short burst is forced; must be ≥ 2.
- TMR_WIDTH, $clog2(TIMEOUT_CYCLES), timeout counter width.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, reset: one clock; asynchronous, active-high.
- enable, input, 1, start/continue bursting; level-sensitive.
- burst_len, input, ADDR_WIDTH+1, requested burst length; sampled on entry to FILL.
- fifo_rd_en, output, 1, FIFO pop strobe (combinational from state).
- fifo_rd_data, input, DATA_WIDTH, FIFO head word; valid whenever !fifo_empty (show-ahead).
- fifo_empty, input, 1, FIFO empty flag.
- fifo_count, input, ADDR_WIDTH+1, FIFO occupancy.
- m_valid, output, 1, output word valid.
- m_data, output, DATA_WIDTH, output word.
- m_last, output, 1, final word of the burst.
- m_short, output, 1, word belongs to a timeout-forced short burst.
- m_ready, input, 1, sink accepts the word when m_valid && m_ready.
- busy, output, 1, state != IDLE.
- burst_count, output, 16, bursts completed (last beat accepted); wraps at 16'hFFFF→0.

Behaviour:
- Reset (async, rst=1): state IDLE, m_valid=0, m_data=0, m_last=0, m_short=0, busy=0, burst_count=0, timer=0, remaining=0.
  - fifo_rd_en=0 throughout reset.
  - A burst in flight is discarded; the held output word is dropped; no pops occur.
- Length clamp: len = 1 if burst_len==0; MAX_BURST if burst_len>MAX_BURST; else burst_len. Latched on FILL entry.
- IDLE: when enable=1 → FILL (latch len, timer=0).
- FILL:
  - enable=0 → IDLE.
  - fifo_count ≥ len → BURST, remaining=len, short=0.
  - Else if fifo_count>0, timer increments each cycle. timer==TIMEOUT_CYCLES-1 → BURST, remaining=fifo_count, short=1.
  - fifo_count==0 holds timer at 0.
- BURST:
  - fifo_rd_en = !fifo_empty && remaining!=0 && (!m_valid || m_ready).
  - On a pop: m_data<=fifo_rd_data, m_valid<=1, m_last<=(remaining==1), m_short<=short, remaining decrements.
  - If the sink accepts and no pop occurs, m_valid<=0.
  - After the pop with remaining==1: → FILL if enable else IDLE. Relatch len and clear timer on FILL entry.
  - enable deassert mid-burst does not abort the burst.
- Output hold: m_valid stays high with m_data/m_last/m_short stable until m_ready.
  - The final word may still be pending after leaving BURST.
  - No new pop occurs until it is accepted.
- Latency:
  - FILL→BURST transition at edge E.
  - fifo_rd_en is high in the cycle after E.
  - The first word appears on m_data with m_valid=1 after edge E+1.
- Throughput: one word per cycle with m_ready held high; no bubble inside a burst.
- burst_count increments on the edge where m_valid && m_ready && m_last.
- fifo_empty during BURST (defensive case): no pop; wait; never underflow.
- All arithmetic is unsigned.
  - remaining and the len compare use ADDR_WIDTH+1 bits.
  - timer saturates; it never wraps within FILL.

Test Plan:
- burst_len=4, enable=1, write 4 words 0x11..0x14, m_ready=1 → 4 consecutive beats 0x11..0x14; m_last only on 0x14; m_short=0; burst_count=1.
- burst_len=4, write 2 words 0xA0,0xA1 then stop → after TIMEOUT_CYCLES fill cycles, 2 beats with m_short=1 and m_last on 0xA1.
- burst_len=8, 8 words queued, m_ready toggles 1/0 each cycle → data held stable while m_ready=0; order preserved; exactly 8 pops; fifo_rd_en never high while m_valid && !m_ready.
- burst_len=0 → bursts of 1 (m_last on every beat); burst_len=20 → clamped to 8 with m_last on the 8th beat.
- Assert rst after 3 of 8 beats → m_valid=0 and busy=0 immediately (asynchronously); no fifo_rd_en during reset; after release, a fresh burst starts from the current FIFO head.
- enable dropped mid-burst with len=4 → all 4 beats complete, then IDLE with busy=0; burst_count set to 0xFFFF, then one more burst → burst_count wraps to 0.
